// File: rtl/fp_multiplier_pipe_if.sv
// rtl/fp_multiplier_pipe_if.sv - operand/result handshake bundle for fp_multiplier_pipe
// Signals:
//   in_valid, in_ready   operand handshake
//   num1, num2           operands, W bits each, packed as {sign, exp, frac}
//   out_valid, out_ready result handshake
//   final_product        result, W bits
//   flags                {invalid, overflow, underflow, inexact}
// Modports:
//   slave  - seen from the multiplier
//   master - seen from the operand source / result consumer
interface fp_multiplier_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num1;
    logic [W-1:0] num2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] final_product;
    logic [3:0]   flags;

    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, final_product, flags
    );

    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, final_product, flags
    );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// rtl/fp_multiplier_pipe.sv - 3-stage pipelined IEEE-754-style floating-point multiplier
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fp_multiplier_pipe_if.slave: in_valid/in_ready/num1/num2,
//          out_valid/out_ready/final_product/flags ({invalid, overflow, underflow, inexact})
// Build option:
//   FPMUL_RNE_EN - defined: round to nearest, ties to even; undefined: truncate.
// Subnormal inputs are flushed to zero and no subnormal results are produced.
module fp_multiplier_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic                 clk,
    input logic                 rst,
    fp_multiplier_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [XW-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
    localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Result class decided in S1; only CLS_NORM needs the arithmetic path.
    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_QNAN,
        CLS_INVALID,
        CLS_INF,
        CLS_ZERO
    } cls_e;

    logic adv;

    // S1 state
    logic                 v1_q, v1_d;
    logic                 s1_q, s1_d;
    cls_e                 c1_q, c1_d;
    logic signed [XW-1:0] e1_q, e1_d;
    logic [MAN_W:0]       ma1_q, ma1_d, mb1_q, mb1_d;

    // S2 state
    logic                 v2_q;
    logic                 s2_q;
    cls_e                 c2_q;
    logic signed [XW-1:0] e2_q;
    logic [PW-1:0]        p2_q, p2_d;

    // S3 (output) state
    logic                 v3_q;
    logic [W-1:0]         prod3_q, prod3_d;
    logic [3:0]           flg3_q, flg3_d;

    // Single global enable: the whole pipe moves or the whole pipe holds.
    assign adv               = !v3_q || bus.out_ready;
    assign bus.in_ready      = adv;
    assign bus.out_valid     = v3_q;
    assign bus.final_product = prod3_q;
    assign bus.flags         = flg3_q;

    // S1: unpack, classify, exponent sum
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign {sa, ea, fa} = bus.num1;
    assign {sb, eb, fb} = bus.num2;
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = (&ea) && ~|fa;
    assign b_inf  = (&eb) && ~|fb;
    assign a_nan  = (&ea) && |fa;
    assign b_nan  = (&eb) && |fb;

    always_comb begin
        v1_d  = bus.in_valid;
        s1_d  = sa ^ sb;
        e1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        ma1_d = {1'b1, fa};
        mb1_d = {1'b1, fb};
        c1_d  = CLS_NORM;
        if (a_nan || b_nan) begin
            c1_d = CLS_QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            c1_d = CLS_INVALID;
        end else if (a_inf || b_inf) begin
            c1_d = CLS_INF;
        end else if (a_zero || b_zero) begin
            c1_d = CLS_ZERO;
        end
    end

    // S2: significand multiply
    assign p2_d = {{(MAN_W+1){1'b0}}, ma1_q} * {{(MAN_W+1){1'b0}}, mb1_q};

    // S3: normalise, round, pack
    logic                 msb, guard, sticky, carry;
    logic [MAN_W-1:0]     frac, frac_r;
    logic signed [XW-1:0] exp_f;
`ifdef FPMUL_RNE_EN
    logic                 round_up;
`endif

    always_comb begin
        msb = p2_q[PW-1];
        // Product is in [1,4): the hidden bit sits at PW-1 or PW-2.
        if (msb) begin
            frac   = p2_q[PW-2 -: MAN_W];
            guard  = p2_q[PW-2-MAN_W];
            sticky = |p2_q[PW-3-MAN_W:0];
        end else begin
            frac   = p2_q[PW-3 -: MAN_W];
            guard  = p2_q[PW-3-MAN_W];
            sticky = |p2_q[PW-4-MAN_W:0];
        end
`ifdef FPMUL_RNE_EN
        round_up        = guard && (sticky || frac[0]);
        {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
`else
        carry  = 1'b0;
        frac_r = frac;
`endif
        // A rounding carry leaves frac_r at zero, i.e. significand 1.0 one binade up.
        exp_f = e2_q + $signed({{(XW-1){1'b0}}, msb}) + $signed({{(XW-1){1'b0}}, carry});

        prod3_d = {s2_q, exp_f[EXP_W-1:0], frac_r};
        flg3_d  = {3'b000, guard || sticky};
        case (c2_q)
            CLS_QNAN: begin
                prod3_d = QNAN;
                flg3_d  = 4'b0000;
            end
            CLS_INVALID: begin
                prod3_d = QNAN;
                flg3_d  = 4'b1000;
            end
            CLS_INF: begin
                prod3_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flg3_d  = 4'b0000;
            end
            CLS_ZERO: begin
                prod3_d = {s2_q, {(W-1){1'b0}}};
                flg3_d  = 4'b0000;
            end
            default: begin
                if (exp_f >= EXP_MAX) begin
                    prod3_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flg3_d  = 4'b0101;
                end else if (exp_f <= EXP_ZERO) begin
                    prod3_d = {s2_q, {(W-1){1'b0}}};
                    flg3_d  = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= CLS_ZERO;
            e1_q    <= '0;
            ma1_q   <= '0;
            mb1_q   <= '0;
            v2_q    <= 1'b0;
            s2_q    <= 1'b0;
            c2_q    <= CLS_ZERO;
            e2_q    <= '0;
            p2_q    <= '0;
            v3_q    <= 1'b0;
            prod3_q <= '0;
            flg3_q  <= '0;
        end else if (adv) begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            e1_q    <= e1_d;
            ma1_q   <= ma1_d;
            mb1_q   <= mb1_d;
            v2_q    <= v1_q;
            s2_q    <= s1_q;
            c2_q    <= c1_q;
            e2_q    <= e1_q;
            p2_q    <= p2_d;
            v3_q    <= v2_q;
            prod3_q <= prod3_d;
            flg3_q  <= flg3_d;
        end
    end
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// tb/tb_fp_multiplier_pipe.sv - directed self-checking bench for fp_multiplier_pipe
module tb_fp_multiplier_pipe;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_multiplier_pipe_if #(.W(32)) bus ();

    fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation with out_ready high: exact 3-cycle latency and result.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ep, input logic [3:0] ef, input string name);
        tick();
        bus.num1      = a;
        bus.num2      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            bus.in_valid = 1'b0;
            #1;
            if (i < 3) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early out_valid at cycle %0d: got %b want 0", name, i, bus.out_valid);
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s latency out_valid: got %b want 1", name, bus.out_valid);
                end
                checks++;
                if (bus.final_product !== ep) begin
                    errors++;
                    $display("FAIL %s product: got %h want %h", name, bus.final_product, ep);
                end
                checks++;
                if (bus.flags !== ef) begin
                    errors++;
                    $display("FAIL %s flags: got %b want %b", name, bus.flags, ef);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.num1      = '0;
        bus.num2      = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.final_product !== 32'h0 || bus.flags !== 4'h0) begin
            errors++;
            $display("FAIL reset data: got %h/%b want 0/0", bus.final_product, bus.flags);
        end
    endtask

    task automatic test_normal();
        logic [31:0] va[4] = '{32'h3F800000, 32'h3FC00000, 32'h41200000, 32'hC0000000};
        logic [31:0] vb[4] = '{32'h3F800000, 32'h3FC00000, 32'h41200000, 32'h40400000};
        logic [31:0] vp[4] = '{32'h3F800000, 32'h40100000, 32'h42C80000, 32'hC0C00000};
        for (int i = 0; i < 4; i++) run_one(va[i], vb[i], vp[i], 4'b0000, $sformatf("normal%0d", i));
    endtask

    task automatic test_special();
        logic [31:0] va[6] = '{32'h40A00000, 32'hFF800000, 32'h00000000,
                               32'h7F000000, 32'h00800000, 32'h7FC00001};
        logic [31:0] vb[6] = '{32'h7F800000, 32'h00000000, 32'h40A00000,
                               32'h7F000000, 32'h00800000, 32'h3F800000};
        logic [31:0] vp[6] = '{32'h7F800000, 32'h7FC00000, 32'h00000000,
                               32'h7F800000, 32'h00000000, 32'h7FC00000};
        logic [3:0]  vf[6] = '{4'b0000, 4'b1000, 4'b0000, 4'b0101, 4'b0011, 4'b0000};
        for (int i = 0; i < 6; i++) run_one(va[i], vb[i], vp[i], vf[i], $sformatf("special%0d", i));
    endtask

    task automatic test_rounding();
        run_one(32'h3ECCCCCD, 32'h40A00000, 32'h40000000, 4'b0001, "round_0p4x5");
`ifdef FPMUL_RNE_EN
        run_one(32'h46445C00, 32'h455A2000, 32'h4C274EE4, 4'b0001, "round_tie");
`else
        run_one(32'h46445C00, 32'h455A2000, 32'h4C274EE3, 4'b0001, "round_tie");
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] opa[5] = '{32'h3F800000, 32'h3FC00000, 32'h41200000, 32'h40000000, 32'h3F000000};
        logic [31:0] opb[5] = '{32'h3F800000, 32'h3FC00000, 32'h41200000, 32'h40400000, 32'h3F000000};
        logic [31:0] expv[5] = '{32'h3F800000, 32'h40100000, 32'h42C80000, 32'h40C00000, 32'h3E800000};
        logic [31:0] got[$];
        int idx = 0;
        for (int cyc = 0; cyc < 60 && got.size() < 5; cyc++) begin
            tick();
            bus.out_ready = (cyc < 2) || (cyc >= 8);
            if (idx < 5) begin
                bus.in_valid = 1'b1;
                bus.num1     = opa[idx];
                bus.num2     = opb[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 3 && cyc < 8) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b stall in_ready cycle %0d: got %b want 0", cyc, bus.in_ready);
                end
                checks++;
                if (bus.out_valid !== 1'b1 || bus.final_product !== expv[0]) begin
                    errors++;
                    $display("FAIL b2b held output cycle %0d: got %b/%h want 1/%h",
                             cyc, bus.out_valid, bus.final_product, expv[0]);
                end
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.final_product);
            if (bus.in_valid && bus.in_ready) idx++;
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL b2b result count: got %0d want 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] !== expv[i]) begin
                errors++;
                $display("FAIL b2b result %0d: got %h want %h", i, got[i], expv[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b duplicate output drain %0d: got %b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.num1      = 32'h41200000;
            bus.num2      = 32'h41200000;
        end
        tick();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.final_product !== 32'h0 || bus.flags !== 4'h0) begin
            errors++;
            $display("FAIL midreset data: got %h/%b want 0/0", bus.final_product, bus.flags);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset stale result cycle %0d: got %b want 0", i, bus.out_valid);
            end
        end
        run_one(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "after_reset");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_rounding();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
